// File: rtl/alu_issue_sched_if.sv
// Handshake and stage-control bundle between the ALU issue scheduler and its
// two requesters (decode issue path and replay path).
interface alu_issue_sched_if #(
    parameter int TAG_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_ready;
    logic             stall;
    logic             flush;
    logic [TAG_W-1:0] flush_tag;
    logic             enable_alu;
    logic             alu_clr_n;
    logic             sel;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_fire;

    modport master (
        output req0_valid, req1_valid, stall, flush, flush_tag,
        input  req0_ready, req1_ready, enable_alu, alu_clr_n, sel, issue_tag, issue_fire
    );

    modport slave (
        input  req0_valid, req1_valid, stall, flush, flush_tag,
        output req0_ready, req1_ready, enable_alu, alu_clr_n, sel, issue_tag, issue_fire
    );
endinterface

// File: rtl/alu_issue_sched.sv
// ALU stage issue scheduler: round-robin (or req1-priority) arbitration between
// decode and replay, with stall hold, post-flush bubbles and wrapping issue tags.
module alu_issue_sched #(
    parameter int TAG_W         = 3,
    parameter int FLUSH_BUBBLES = 2,
    parameter int PRIO          = 0
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_sched_if.slave   bus
);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'((FLUSH_BUBBLES > 1) ? FLUSH_BUBBLES - 2 : 0);

    state_t           state;
    logic             last_grant;
    logic             sel_q;
    logic [TAG_W-1:0] tag_cnt;
    logic [3:0]       drain_cnt;

    logic             run_ok;
    logic             win;
    logic             grant0;
    logic             grant1;
    logic             fire;

    logic             ready0_o;
    logic             ready1_o;
    logic             enable_o;
    logic             clr_n_o;
    logic             sel_o;
    logic [TAG_W-1:0] tag_o;
    logic             fire_o;

    // win is the requester that would be chosen if both asked; with one valid it is that one.
    always_comb begin
        run_ok = (state == RUN) && !bus.flush && !bus.stall;
        if (bus.req0_valid && bus.req1_valid) begin
            win = (PRIO != 0) ? 1'b1 : ~last_grant;
        end else begin
            win = bus.req1_valid;
        end
        grant0 = run_ok && bus.req0_valid && !win;
        grant1 = run_ok && bus.req1_valid && win;
        fire   = grant0 || grant1;
    end

    // Outputs are gated by reset so an asserted reset drops any in-flight grant at once.
    always_comb begin
        ready0_o = 1'b0;
        ready1_o = 1'b0;
        enable_o = 1'b0;
        clr_n_o  = 1'b0;
        sel_o    = 1'b0;
        tag_o    = '0;
        fire_o   = 1'b0;
        if (reset) begin
            ready0_o = grant0;
            ready1_o = grant1;
            fire_o   = fire;
            sel_o    = fire ? win : sel_q;
            tag_o    = tag_cnt;
            if (bus.flush || (state == DRAIN)) begin
                enable_o = 1'b1;
                clr_n_o  = 1'b0;
            end else if (bus.stall) begin
                enable_o = 1'b0;
                clr_n_o  = 1'b1;
            end else begin
                enable_o = 1'b1;
                clr_n_o  = fire;
            end
        end
    end

    assign bus.req0_ready = ready0_o;
    assign bus.req1_ready = ready1_o;
    assign bus.enable_alu = enable_o;
    assign bus.alu_clr_n  = clr_n_o;
    assign bus.sel        = sel_o;
    assign bus.issue_tag  = tag_o;
    assign bus.issue_fire = fire_o;

    // Flush outranks everything; the flush cycle itself is the first of the bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            last_grant <= 1'b1;
            sel_q      <= 1'b0;
            tag_cnt    <= '0;
            drain_cnt  <= '0;
        end else if (bus.flush) begin
            tag_cnt <= bus.flush_tag;
            if (FLUSH_BUBBLES == 1) begin
                state <= RUN;
            end else begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_LOAD;
            end
        end else if (state == DRAIN) begin
            if (drain_cnt == 4'd0) begin
                state <= RUN;
            end else begin
                drain_cnt <= drain_cnt - 4'd1;
            end
        end else if (fire) begin
            tag_cnt    <= tag_cnt + TAG_W'(1);
            last_grant <= win;
            sel_q      <= win;
        end
    end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench: two schedulers (round-robin/2 bubbles and req1-priority/3 bubbles)
// share one random+directed stimulus stream and are compared against a reference model.
module tb_alu_issue_sched;

    localparam int TAG_W = 3;

    typedef struct {
        logic             r0, r1, en, clr, sel, fire;
        logic [TAG_W-1:0] tag;
        logic             chk_sel, chk_tag;
    } exp_t;

    typedef struct {
        int tag;
        int last;
        int bubbles;
        int sel;
    } mst_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q0[$];
    exp_t q1[$];
    mst_t m0;
    mst_t m1;

    alu_issue_sched_if #(.TAG_W(TAG_W)) if0 ();
    alu_issue_sched_if #(.TAG_W(TAG_W)) if1 ();

    alu_issue_sched #(.TAG_W(TAG_W), .FLUSH_BUBBLES(2), .PRIO(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    alu_issue_sched #(.TAG_W(TAG_W), .FLUSH_BUBBLES(3), .PRIO(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    // Reference behaviour: bubbles is the number of forced bubble cycles still owed after a flush.
    task automatic modelStep(input int prio, input int fb, input logic rst, input logic v0,
                             input logic v1, input logic st, input logic fl,
                             input logic [TAG_W-1:0] ft, inout mst_t s, output exp_t e);
        int w;
        e = '{r0: 1'b0, r1: 1'b0, en: 1'b0, clr: 1'b0, sel: 1'b0, fire: 1'b0,
              tag: '0, chk_sel: 1'b0, chk_tag: 1'b0};
        if (!rst) begin
            e.chk_sel = 1'b1;
            e.chk_tag = 1'b1;
            s = '{tag: 0, last: 1, bubbles: 0, sel: 0};
        end else if (fl) begin
            e.en = 1'b1;
            s.tag = int'(ft);
            s.bubbles = fb - 1;
        end else if (s.bubbles > 0) begin
            e.en = 1'b1;
            s.bubbles = s.bubbles - 1;
        end else if (st) begin
            e.clr = 1'b1;
        end else if (!v0 && !v1) begin
            e.en = 1'b1;
            e.sel = s.sel[0];
            e.chk_sel = 1'b1;
        end else begin
            if (v0 && v1) w = (prio != 0) ? 1 : 1 - s.last;
            else w = v1 ? 1 : 0;
            e.en = 1'b1;
            e.clr = 1'b1;
            e.fire = 1'b1;
            e.r0 = (w == 0);
            e.r1 = (w == 1);
            e.sel = w[0];
            e.tag = s.tag[TAG_W-1:0];
            e.chk_sel = 1'b1;
            e.chk_tag = 1'b1;
            s.tag = (s.tag + 1) % (1 << TAG_W);
            s.last = w;
            s.sel = w;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v0, input logic v1, input logic st,
                                 input logic fl, input logic [TAG_W-1:0] ft);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        if0.req0_valid = v0; if0.req1_valid = v1; if0.stall = st; if0.flush = fl; if0.flush_tag = ft;
        if1.req0_valid = v0; if1.req1_valid = v1; if1.stall = st; if1.flush = fl; if1.flush_tag = ft;
        modelStep(0, 2, rst, v0, v1, st, fl, ft, m0, e);
        q0.push_back(e);
        modelStep(1, 3, rst, v0, v1, st, fl, ft, m1, e);
        q1.push_back(e);
    endtask

    task automatic checkOutput(input int inst, input exp_t e, input logic r0, input logic r1,
                               input logic en, input logic clr, input logic sel, input logic fire,
                               input logic [TAG_W-1:0] tag);
        logic bad;
        vectors++;
        bad = (r0 !== e.r0) || (r1 !== e.r1) || (en !== e.en) || (clr !== e.clr) ||
              (fire !== e.fire) || (e.chk_sel && (sel !== e.sel)) ||
              (e.chk_tag && (tag !== e.tag));
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL dut%0d vec%0d got r0=%b r1=%b en=%b clr_n=%b sel=%b fire=%b tag=%0d exp r0=%b r1=%b en=%b clr_n=%b sel=%b fire=%b tag=%0d (chk_sel=%b chk_tag=%b)",
                     inst, vectors, r0, r1, en, clr, sel, fire, tag,
                     e.r0, e.r1, e.en, e.clr, e.sel, e.fire, e.tag, e.chk_sel, e.chk_tag);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                checkOutput(0, e, if0.req0_ready, if0.req1_ready, if0.enable_alu, if0.alu_clr_n,
                            if0.sel, if0.issue_fire, if0.issue_tag);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checkOutput(1, e, if1.req0_ready, if1.req1_ready, if1.enable_alu, if1.alu_clr_n,
                            if1.sel, if1.issue_fire, if1.issue_tag);
            end
        end
    end

    initial begin
        m0 = '{tag: 0, last: 1, bubbles: 0, sel: 0};
        m1 = '{tag: 0, last: 1, bubbles: 0, sel: 0};
        if0.req0_valid = 1'b0; if0.req1_valid = 1'b0; if0.stall = 1'b0; if0.flush = 1'b0; if0.flush_tag = '0;
        if1.req0_valid = 1'b0; if1.req1_valid = 1'b0; if1.stall = 1'b0; if1.flush = 1'b0; if1.flush_tag = '0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(99) != 0), 1'($urandom), 1'($urandom),
                          ($urandom_range(4) == 0), ($urandom_range(19) == 0), 3'($urandom));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        @(negedge clk);
        #1;
        if ((q0.size() != 0) || (q1.size() != 0)) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain got %0d/%0d pending entries, exp 0/0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
